// File: rtl/rca_config_bank.sv
// Double-buffered RCA register-mapping store: software writes a per-RCA shadow
// bank, and a commit copies it to the active bank once the target RCA is idle.
module rca_config_bank #(
   parameter int NUM_RCAS        = 4,
   parameter int NUM_READ_PORTS  = 4,
   parameter int NUM_WRITE_PORTS = 2,
   parameter int REG_ADDR_W      = 5,
   localparam int SEL_W  = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
   localparam int PORT_N = (NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS,
   localparam int PORT_W = (PORT_N > 1) ? $clog2(PORT_N) : 1,
   localparam int SRC_W  = NUM_READ_PORTS * REG_ADDR_W,
   localparam int DST_W  = NUM_WRITE_PORTS * REG_ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SEL_W-1:0]           rca_sel,
   output logic [SRC_W-1:0]           rca_src_reg_addrs,
   output logic [DST_W-1:0]           rca_dest_reg_addrs,
   output logic [NUM_READ_PORTS-1:0]  rca_src_en,
   output logic [NUM_WRITE_PORTS-1:0] rca_dest_en,
   output logic                       rca_cfg_valid,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [SEL_W-1:0]           wr_rca,
   input  logic                       wr_is_dest,
   input  logic [PORT_W-1:0]          wr_port,
   input  logic [REG_ADDR_W-1:0]      wr_reg_addr,
   input  logic                       wr_port_en,
   input  logic                       commit_valid,
   output logic                       commit_ready,
   input  logic [SEL_W-1:0]           commit_rca,
   input  logic [NUM_RCAS-1:0]        rca_busy,
   output logic [NUM_RCAS-1:0]        commit_pending,
   output logic                       cfg_err
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   state_e                     state_q       [NUM_RCAS];
   state_e                     state_d       [NUM_RCAS];
   logic [SRC_W-1:0]           sh_src_addr_q [NUM_RCAS];
   logic [SRC_W-1:0]           sh_src_addr_d [NUM_RCAS];
   logic [DST_W-1:0]           sh_dst_addr_q [NUM_RCAS];
   logic [DST_W-1:0]           sh_dst_addr_d [NUM_RCAS];
   logic [NUM_READ_PORTS-1:0]  sh_src_en_q   [NUM_RCAS];
   logic [NUM_READ_PORTS-1:0]  sh_src_en_d   [NUM_RCAS];
   logic [NUM_WRITE_PORTS-1:0] sh_dst_en_q   [NUM_RCAS];
   logic [NUM_WRITE_PORTS-1:0] sh_dst_en_d   [NUM_RCAS];
   logic [SRC_W-1:0]           ac_src_addr_q [NUM_RCAS];
   logic [SRC_W-1:0]           ac_src_addr_d [NUM_RCAS];
   logic [DST_W-1:0]           ac_dst_addr_q [NUM_RCAS];
   logic [DST_W-1:0]           ac_dst_addr_d [NUM_RCAS];
   logic [NUM_READ_PORTS-1:0]  ac_src_en_q   [NUM_RCAS];
   logic [NUM_READ_PORTS-1:0]  ac_src_en_d   [NUM_RCAS];
   logic [NUM_WRITE_PORTS-1:0] ac_dst_en_q   [NUM_RCAS];
   logic [NUM_WRITE_PORTS-1:0] ac_dst_en_d   [NUM_RCAS];
   logic [NUM_RCAS-1:0]        cfg_valid_q;
   logic [NUM_RCAS-1:0]        cfg_valid_d;
   logic                       err_q;
   logic                       err_d;

   logic wr_in_range;
   logic wr_target_pending;
   logic wr_fire;
   logic wr_apply;
   logic cm_in_range;
   logic cm_fire;
   logic cm_apply;

   // Handshake decode; out-of-range requests still complete so the bus never hangs.
   always_comb begin
      wr_target_pending = 1'b0;
      for (int r = 0; r < NUM_RCAS; r++) begin
         if (int'(wr_rca) == r && state_q[r] == ST_PENDING) begin
            wr_target_pending = 1'b1;
         end
      end
      wr_in_range = (int'(wr_rca) < NUM_RCAS) &&
                    (wr_is_dest ? (int'(wr_port) < NUM_WRITE_PORTS)
                                : (int'(wr_port) < NUM_READ_PORTS));
      cm_in_range  = int'(commit_rca) < NUM_RCAS;
      wr_ready     = !rst && !wr_target_pending;
      commit_ready = !rst;
      wr_fire      = wr_valid && wr_ready;
      cm_fire      = commit_valid && commit_ready;
      wr_apply     = wr_fire && wr_in_range;
      cm_apply     = cm_fire && cm_in_range;
      err_d        = (wr_fire && !wr_in_range) || (cm_fire && !cm_in_range);
   end

   always_comb begin
      for (int r = 0; r < NUM_RCAS; r++) begin
         state_d[r]       = state_q[r];
         sh_src_addr_d[r] = sh_src_addr_q[r];
         sh_dst_addr_d[r] = sh_dst_addr_q[r];
         sh_src_en_d[r]   = sh_src_en_q[r];
         sh_dst_en_d[r]   = sh_dst_en_q[r];
         ac_src_addr_d[r] = ac_src_addr_q[r];
         ac_dst_addr_d[r] = ac_dst_addr_q[r];
         ac_src_en_d[r]   = ac_src_en_q[r];
         ac_dst_en_d[r]   = ac_dst_en_q[r];
         cfg_valid_d[r]   = cfg_valid_q[r];

         if (wr_apply && int'(wr_rca) == r) begin
            if (wr_is_dest) begin
               for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                  if (int'(wr_port) == p) begin
                     sh_dst_addr_d[r][p*REG_ADDR_W +: REG_ADDR_W] = wr_reg_addr;
                     sh_dst_en_d[r][p] = wr_port_en;
                  end
               end
            end else begin
               for (int p = 0; p < NUM_READ_PORTS; p++) begin
                  if (int'(wr_port) == p) begin
                     sh_src_addr_d[r][p*REG_ADDR_W +: REG_ADDR_W] = wr_reg_addr;
                     sh_src_en_d[r][p] = wr_port_en;
                  end
               end
            end
         end

         // The shadow copied here already holds any write accepted on the commit edge.
         case (state_q[r])
            ST_IDLE: begin
               if (cm_apply && int'(commit_rca) == r) begin
                  state_d[r] = ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (!rca_busy[r]) begin
                  ac_src_addr_d[r] = sh_src_addr_q[r];
                  ac_dst_addr_d[r] = sh_dst_addr_q[r];
                  ac_src_en_d[r]   = sh_src_en_q[r];
                  ac_dst_en_d[r]   = sh_dst_en_q[r];
                  cfg_valid_d[r]   = 1'b1;
                  state_d[r]       = ST_IDLE;
               end
            end
            default: state_d[r] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_RCAS; r++) begin
            state_q[r]       <= ST_IDLE;
            sh_src_addr_q[r] <= '0;
            sh_dst_addr_q[r] <= '0;
            sh_src_en_q[r]   <= '0;
            sh_dst_en_q[r]   <= '0;
            ac_src_addr_q[r] <= '0;
            ac_dst_addr_q[r] <= '0;
            ac_src_en_q[r]   <= '0;
            ac_dst_en_q[r]   <= '0;
         end
         cfg_valid_q <= '0;
         err_q       <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_RCAS; r++) begin
            state_q[r]       <= state_d[r];
            sh_src_addr_q[r] <= sh_src_addr_d[r];
            sh_dst_addr_q[r] <= sh_dst_addr_d[r];
            sh_src_en_q[r]   <= sh_src_en_d[r];
            sh_dst_en_q[r]   <= sh_dst_en_d[r];
            ac_src_addr_q[r] <= ac_src_addr_d[r];
            ac_dst_addr_q[r] <= ac_dst_addr_d[r];
            ac_src_en_q[r]   <= ac_src_en_d[r];
            ac_dst_en_q[r]   <= ac_dst_en_d[r];
         end
         cfg_valid_q <= cfg_valid_d;
         err_q       <= err_d;
      end
   end

   // Read side: an out-of-range select matches no RCA and leaves every output at 0.
   always_comb begin
      rca_src_reg_addrs  = '0;
      rca_dest_reg_addrs = '0;
      rca_src_en         = '0;
      rca_dest_en        = '0;
      rca_cfg_valid      = 1'b0;
      for (int r = 0; r < NUM_RCAS; r++) begin
         commit_pending[r] = (state_q[r] == ST_PENDING);
         if (int'(rca_sel) == r) begin
            rca_src_reg_addrs  = ac_src_addr_q[r];
            rca_dest_reg_addrs = ac_dst_addr_q[r];
            rca_src_en         = ac_src_en_q[r];
            rca_dest_en        = ac_dst_en_q[r];
            rca_cfg_valid      = cfg_valid_q[r];
         end
      end
   end

   assign cfg_err = err_q;

endmodule

// File: tb/tb_rca_config_bank.sv
// Scoreboard bench for rca_config_bank: expected active-bank snapshots are queued
// when a commit is driven and compared once the DUT finishes the copy.
module tb_rca_config_bank;

   localparam int NR = 5;

   logic        clk;
   logic        rst;
   logic [2:0]  rca_sel;
   logic [19:0] rca_src_reg_addrs;
   logic [9:0]  rca_dest_reg_addrs;
   logic [3:0]  rca_src_en;
   logic [1:0]  rca_dest_en;
   logic        rca_cfg_valid;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_rca;
   logic        wr_is_dest;
   logic [1:0]  wr_port;
   logic [4:0]  wr_reg_addr;
   logic        wr_port_en;
   logic        commit_valid;
   logic        commit_ready;
   logic [2:0]  commit_rca;
   logic [NR-1:0] rca_busy;
   logic [NR-1:0] commit_pending;
   logic        cfg_err;

   rca_config_bank #(.NUM_RCAS(NR)) dut (
      .clk                (clk),
      .rst                (rst),
      .rca_sel            (rca_sel),
      .rca_src_reg_addrs  (rca_src_reg_addrs),
      .rca_dest_reg_addrs (rca_dest_reg_addrs),
      .rca_src_en         (rca_src_en),
      .rca_dest_en        (rca_dest_en),
      .rca_cfg_valid      (rca_cfg_valid),
      .wr_valid           (wr_valid),
      .wr_ready           (wr_ready),
      .wr_rca             (wr_rca),
      .wr_is_dest         (wr_is_dest),
      .wr_port            (wr_port),
      .wr_reg_addr        (wr_reg_addr),
      .wr_port_en         (wr_port_en),
      .commit_valid       (commit_valid),
      .commit_ready       (commit_ready),
      .commit_rca         (commit_rca),
      .rca_busy           (rca_busy),
      .commit_pending     (commit_pending),
      .cfg_err            (cfg_err)
   );

   typedef struct {
      logic [2:0]  sel;
      logic [63:0] exp;
      string       tag;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int n_vec = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic [19:0] src, input logic [9:0] dst,
                                      input logic [3:0] sen, input logic [1:0] den,
                                      input logic v);
      return {27'b0, v, den, sen, dst, src};
   endfunction

   function automatic logic [63:0] snap();
      return {27'b0, rca_cfg_valid, rca_dest_en, rca_src_en, rca_dest_reg_addrs, rca_src_reg_addrs};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [2:0] sel, input logic [63:0] exp);
      sb_entry_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic observe();
      sb_entry_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         rca_sel = e.sel;
         #1;
         chk(e.tag, snap(), e.exp);
      end
   endtask

   task automatic chk_read(input string tag, input logic [2:0] sel, input logic [63:0] exp);
      rca_sel = sel;
      #1;
      chk(tag, snap(), exp);
   endtask

   task automatic do_write(input logic [2:0] r, input logic dest, input logic [1:0] port,
                           input logic [4:0] addr, input logic en);
      wr_valid    = 1'b1;
      wr_rca      = r;
      wr_is_dest  = dest;
      wr_port     = port;
      wr_reg_addr = addr;
      wr_port_en  = en;
      #1;
      chk("wr_ready", 64'(wr_ready), 64'd1);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_commit(input logic [2:0] r);
      commit_valid = 1'b1;
      commit_rca   = r;
      #1;
      chk("commit_ready", 64'(commit_ready), 64'd1);
      tick();
      commit_valid = 1'b0;
   endtask

   localparam logic [63:0] ZERO = 64'd0;

   initial begin
      rst = 1'b1; rca_sel = '0; wr_valid = 1'b0; wr_rca = '0; wr_is_dest = 1'b0;
      wr_port = '0; wr_reg_addr = '0; wr_port_en = 1'b0; commit_valid = 1'b0;
      commit_rca = '0; rca_busy = '0;
      tick();
      tick();
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_commit_ready", 64'(commit_ready), 64'd0);

      // Reset state
      rst = 1'b0;
      #1;
      chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
      chk("post_rst_commit_ready", 64'(commit_ready), 64'd1);
      chk("post_rst_pending", 64'(commit_pending), 64'd0);
      chk("post_rst_err", 64'(cfg_err), 64'd0);
      push_exp("reset_read_rca0", 3'd0, ZERO);
      observe();

      // Write then commit RCA 1 with busy low
      do_write(3'd1, 1'b0, 2'd2, 5'd17, 1'b1);
      chk_read("rca1_before_commit", 3'd1, ZERO);
      push_exp("rca1_committed", 3'd1, mk(20'd17 << 10, 10'd0, 4'b0100, 2'b00, 1'b1));
      do_commit(3'd1);
      chk("rca1_pending_set", 64'(commit_pending), 64'b00010);
      chk_read("rca1_mid_commit", 3'd1, ZERO);
      tick();
      chk("rca1_pending_clr", 64'(commit_pending), 64'd0);
      observe();

      // Deferred commit on RCA 2 while busy; RCA 3 writes keep flowing
      do_write(3'd2, 1'b1, 2'd0, 5'd3, 1'b1);
      rca_busy = 5'b00100;
      do_commit(3'd2);
      wr_valid = 1'b1; wr_rca = 3'd2; wr_is_dest = 1'b1; wr_port = 2'd0;
      wr_reg_addr = 5'd30; wr_port_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("rca2_stall_ready", 64'(wr_ready), 64'd0);
         chk("rca2_stall_pending", 64'(commit_pending[2]), 64'd1);
         tick();
      end
      wr_valid = 1'b0;
      do_write(3'd3, 1'b0, 2'd0, 5'd7, 1'b1);
      chk("rca2_still_pending", 64'(commit_pending), 64'b00100);
      chk_read("rca2_active_held", 3'd2, ZERO);
      push_exp("rca2_committed", 3'd2, mk(20'd0, 10'd3, 4'b0000, 2'b01, 1'b1));
      rca_busy = 5'b00000;
      tick();
      chk("rca2_pending_clr", 64'(commit_pending), 64'd0);
      wr_rca = 3'd2;
      #1;
      chk("rca2_wr_ready_back", 64'(wr_ready), 64'd1);
      observe();
      chk_read("rca3_shadow_only", 3'd3, ZERO);
      push_exp("rca3_committed", 3'd3, mk(20'd7, 10'd0, 4'b0001, 2'b00, 1'b1));
      do_commit(3'd3);
      tick();
      observe();

      // Same-cycle write and commit to RCA 0
      wr_valid = 1'b1; wr_rca = 3'd0; wr_is_dest = 1'b1; wr_port = 2'd1;
      wr_reg_addr = 5'd9; wr_port_en = 1'b1;
      commit_valid = 1'b1; commit_rca = 3'd0;
      push_exp("rca0_same_cycle", 3'd0, mk(20'd0, 10'd9 << 5, 4'b0000, 2'b10, 1'b1));
      #1;
      chk("same_cycle_wr_ready", 64'(wr_ready), 64'd1);
      tick();
      wr_valid = 1'b0; commit_valid = 1'b0;
      tick();
      observe();

      // Out-of-range write, out-of-range commit, and both together
      do_write(3'd0, 1'b1, 2'd3, 5'd31, 1'b1);
      chk("oor_wr_err_pulse", 64'(cfg_err), 64'd1);
      tick();
      chk("oor_wr_err_clear", 64'(cfg_err), 64'd0);
      do_commit(3'd5);
      chk("oor_cm_err_pulse", 64'(cfg_err), 64'd1);
      chk("oor_cm_no_pending", 64'(commit_pending), 64'd0);
      tick();
      chk("oor_cm_err_clear", 64'(cfg_err), 64'd0);
      wr_valid = 1'b1; wr_rca = 3'd6; wr_is_dest = 1'b0; wr_port = 2'd0;
      wr_reg_addr = 5'd21; wr_port_en = 1'b1;
      commit_valid = 1'b1; commit_rca = 3'd7;
      tick();
      wr_valid = 1'b0; commit_valid = 1'b0;
      chk("oor_both_err_pulse", 64'(cfg_err), 64'd1);
      tick();
      chk("oor_both_err_clear", 64'(cfg_err), 64'd0);
      chk_read("oor_sel_reads_zero", 3'd5, ZERO);
      push_exp("rca0_unchanged", 3'd0, mk(20'd0, 10'd9 << 5, 4'b0000, 2'b10, 1'b1));
      do_commit(3'd0);
      tick();
      observe();

      // Reset while RCA 1 is pending behind busy
      rca_busy = 5'b00010;
      do_commit(3'd1);
      chk("rst_case_pending", 64'(commit_pending), 64'b00010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rca_busy = '0;
      #1;
      chk("rst_drop_pending", 64'(commit_pending), 64'd0);
      chk_read("rst_rca1_zero", 3'd1, ZERO);
      tick();
      chk_read("rst_rca1_stays_zero", 3'd1, ZERO);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
